// File: rtl/acq_pkg.sv
// Shared types and defaults for the acquisition sequencer and its address counter.
// Latency: none (declarations only); backpressure: n/a.
package acq_pkg;

    localparam int ACQ_ADDR_BITS = 19;
    localparam int ACQ_REV_BITS  = 8;

    typedef enum logic [2:0] {
        ACQ_IDLE     = 3'd0,
        ACQ_WAIT_IDX = 3'd1,
        ACQ_ACQUIRE  = 3'd2,
        ACQ_DRAIN0   = 3'd3,
        ACQ_DRAIN1   = 3'd4
    } acq_state_e;

endpackage

// File: rtl/acq_addr_counter.sv
// Saturating write-address counter with clear and full flag; 1-cycle update latency.
// Backpressure: increments are ignored once full, address holds at its maximum.
module acq_addr_counter import acq_pkg::*; #(
    parameter int ADDR_BITS = ACQ_ADDR_BITS
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic                 inc_i,
    output logic [ADDR_BITS-1:0] addr_o,
    output logic                 at_max_o,
    output logic                 full_o
);

    localparam logic [ADDR_BITS-1:0] ADDR_MAX = '1;

    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 full_q, full_d;

    always_comb begin
        addr_d = addr_q;
        full_d = full_q;
        if (clr_i) begin
            addr_d = '0;
            full_d = 1'b0;
        end else if (inc_i && !full_q) begin
            // The last location sets full instead of wrapping.
            if (addr_q == ADDR_MAX) begin
                full_d = 1'b1;
            end else begin
                addr_d = addr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q <= '0;
            full_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            full_q <= full_d;
        end
    end

    assign addr_o   = addr_q;
    assign at_max_o = (addr_q == ADDR_MAX);
    assign full_o   = full_q;

endmodule

// File: rtl/acq_sequencer.sv
// Sequences one disc acquisition: arm, optional index wait, RUN for N revolutions, drain.
// RAM_WE is combinational from RD_WRITE; writes beyond the last RAM location are dropped.
module acq_sequencer import acq_pkg::*; #(
    parameter int ADDR_BITS = ACQ_ADDR_BITS,
    parameter int REV_BITS  = ACQ_REV_BITS
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic                 wait_index_i,
    input  logic [REV_BITS-1:0]  rev_count_i,
    input  logic                 index_in_i,
    input  logic                 rd_write_i,
    output logic                 run_o,
    output logic                 ram_we_o,
    output logic [ADDR_BITS-1:0] ram_addr_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 mem_full_o,
    output logic [REV_BITS-1:0]  revs_seen_o
);

    localparam logic [REV_BITS-1:0] REVS_MAX = '1;

    acq_state_e          state_q, state_d;
    logic                run_q, run_d;
    logic                done_q, done_d;
    logic [REV_BITS-1:0] revs_q, revs_d;
    logic                idx_prev_q;

    logic idx_rise;
    logic accepting;
    logic ram_we;
    logic addr_clr;
    logic at_max;
    logic mem_full;
    logic fill_last;
    logic rev_hit;

    assign idx_rise  = index_in_i & ~idx_prev_q;
    assign accepting = (state_q == ACQ_ACQUIRE) || (state_q == ACQ_DRAIN0) ||
                       (state_q == ACQ_DRAIN1);
    assign ram_we    = rd_write_i & accepting & ~mem_full;
    assign fill_last = ram_we & at_max;
    // Extra bit keeps the compare exact when rev_count is at its maximum.
    assign rev_hit   = (rev_count_i != '0) && idx_rise &&
                       (({1'b0, revs_q} + 1'b1) == {1'b0, rev_count_i});

    always_comb begin
        state_d  = state_q;
        done_d   = done_q;
        revs_d   = revs_q;
        addr_clr = 1'b0;
        case (state_q)
            ACQ_IDLE: begin
                if (start_i) begin
                    addr_clr = 1'b1;
                    revs_d   = '0;
                    done_d   = 1'b0;
                    state_d  = wait_index_i ? ACQ_WAIT_IDX : ACQ_ACQUIRE;
                end
            end
            ACQ_WAIT_IDX: begin
                if (abort_i) begin
                    state_d = ACQ_DRAIN0;
                end else if (idx_rise) begin
                    state_d = ACQ_ACQUIRE;
                end
            end
            ACQ_ACQUIRE: begin
                if (idx_rise && (revs_q != REVS_MAX)) begin
                    revs_d = revs_q + 1'b1;
                end
                if (abort_i || fill_last || mem_full || rev_hit) begin
                    state_d = ACQ_DRAIN0;
                end
            end
            ACQ_DRAIN0: state_d = ACQ_DRAIN1;
            ACQ_DRAIN1: begin
                state_d = ACQ_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ACQ_IDLE;
        endcase
        run_d = (state_d == ACQ_ACQUIRE);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ACQ_IDLE;
            run_q      <= 1'b0;
            done_q     <= 1'b0;
            revs_q     <= '0;
            idx_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            done_q     <= done_d;
            revs_q     <= revs_d;
            idx_prev_q <= index_in_i;
        end
    end

    acq_addr_counter #(
        .ADDR_BITS (ADDR_BITS)
    ) u_addr (
        .clk_i    (clock_i),
        .rst_i    (reset_i),
        .clr_i    (addr_clr),
        .inc_i    (ram_we),
        .addr_o   (ram_addr_o),
        .at_max_o (at_max),
        .full_o   (mem_full)
    );

    assign run_o       = run_q;
    assign ram_we_o    = ram_we;
    assign busy_o      = (state_q != ACQ_IDLE);
    assign done_o      = done_q;
    assign mem_full_o  = mem_full;
    assign revs_seen_o = revs_q;

endmodule
